// File: rtl/weight_stream_ctrl.sv
// Streams the coefficient ROM into the convolution weight FIFO, replaying the
// full kernel set repeat_count times per start behind a 2-entry prefetch buffer.
//
// state  | meaning
// IDLE   | waiting for start; repeat_count sampled with it
// STREAM | issuing ROM reads and draining the prefetch buffer into the FIFO
// DONE   | one-cycle completion pulse, then back to IDLE
module weight_stream_ctrl #(
   parameter int MEM_SIZE   = 64,
   parameter int DATA_WIDTH = 16,
   parameter int REPEAT_W   = 8,
   localparam int AW        = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  start,
   input  logic [REPEAT_W-1:0]   repeat_count,
   output logic                  busy,
   output logic                  done,
   output logic [AW-1:0]         rom_address,
   output logic                  rom_ce,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] output_V_din,
   input  logic                  output_V_full_n,
   output logic                  output_V_write
);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t                state, state_nxt;
   logic [AW-1:0]         addr;
   logic [REPEAT_W-1:0]   pass_cnt, pass_tot;
   logic                  issue_done, in_flight;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] buf_head, buf_tail;
   logic                  push, pop, last_addr, last_pass;
   logic [2:0]            committed;

   assign push      = in_flight;
   assign pop       = (occ != 2'd0) && output_V_full_n;
   assign last_addr = (addr == AW'(MEM_SIZE - 1));
   assign last_pass = (pass_cnt == pass_tot - REPEAT_W'(1));
   // Slots already claimed once this cycle's pop is accounted for.
   assign committed = 3'(occ) + 3'(in_flight) - 3'(pop);

   always_comb begin
      state_nxt = state;
      rom_ce    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (repeat_count == '0) ? DONE : STREAM;
         end
         STREAM: begin
            rom_ce = !issue_done && (committed < 3'd2);
            if (issue_done && !in_flight &&
                ((occ == 2'd0) || ((occ == 2'd1) && pop)))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy           = (state != IDLE);
   assign done           = (state == DONE);
   assign rom_address    = addr;
   assign output_V_write = pop;
   assign output_V_din   = buf_head;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         addr       <= '0;
         pass_cnt   <= '0;
         pass_tot   <= '0;
         issue_done <= 1'b0;
         in_flight  <= 1'b0;
      end else begin
         in_flight <= rom_ce;
         if ((state == IDLE) && start) begin
            addr       <= '0;
            pass_cnt   <= '0;
            pass_tot   <= repeat_count;
            issue_done <= 1'b0;
         end else if (rom_ce) begin
            if (last_addr) begin
               addr     <= '0;
               pass_cnt <= pass_cnt + REPEAT_W'(1);
               if (last_pass) issue_done <= 1'b1;
            end else begin
               addr <= addr + AW'(1);
            end
         end
      end
   end

   // Issue throttling guarantees a push never lands on a full buffer.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         occ      <= 2'd0;
         buf_head <= '0;
         buf_tail <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) buf_head <= rom_q;
               else             buf_tail <= rom_q;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf_head <= buf_tail;
               occ      <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  buf_head <= rom_q;
               end else begin
                  buf_head <= buf_tail;
                  buf_tail <= rom_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Randomized bench for weight_stream_ctrl: a queue of expected coefficients is
// built from the kernel-replay rule and every FIFO write is matched against it.
module tb_weight_stream_ctrl;
   localparam int MEM = 8;
   localparam int DW  = 16;
   localparam int RW  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance, MEM_SIZE = 8
   logic          start, busy, done, rom_ce, full_n, wr;
   logic [RW-1:0] rep;
   logic [2:0]    addr;
   logic [DW-1:0] rom_q, din;
   logic [DW-1:0] rom [MEM];

   // single-word instance, MEM_SIZE = 1
   logic          start1, busy1, done1, ce1, wr1, full_n1;
   logic [RW-1:0] rep1;
   logic [0:0]    addr1;
   logic [DW-1:0] q1, din1, rom1_word;

   weight_stream_ctrl #(.MEM_SIZE(MEM), .DATA_WIDTH(DW), .REPEAT_W(RW)) u_dut (
      .ap_clk(clk), .ap_rst(rst), .start(start), .repeat_count(rep),
      .busy(busy), .done(done), .rom_address(addr), .rom_ce(rom_ce),
      .rom_q(rom_q), .output_V_din(din), .output_V_full_n(full_n),
      .output_V_write(wr));

   weight_stream_ctrl #(.MEM_SIZE(1), .DATA_WIDTH(DW), .REPEAT_W(RW)) u_dut1 (
      .ap_clk(clk), .ap_rst(rst), .start(start1), .repeat_count(rep1),
      .busy(busy1), .done(done1), .rom_address(addr1), .rom_ce(ce1),
      .rom_q(q1), .output_V_din(din1), .output_V_full_n(full_n1),
      .output_V_write(wr1));

   // ROMs with one-cycle read latency
   always @(posedge clk) if (rom_ce) rom_q <= rom[addr];
   always @(posedge clk) if (ce1) q1 <= rom1_word;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model state for the main instance
   logic [DW-1:0] exp_q[$];
   bit mon_on = 0;
   int t0, issued, n_wr, first_wr, last_wr, done_cyc, done_cnt, busy_low, win_wr, max_out;

   always @(negedge clk) begin
      int n;
      if (mon_on && !rst) begin
         n = cyc - t0;
         if (rom_ce) begin
            chk("rom_address", 32'(addr), 32'(issued % MEM));
            issued++;
         end
         if (wr) begin
            if (exp_q.size() == 0) chk("unexpected_write", 32'(wr), 32'd0);
            else chk("din", 32'(din), 32'(exp_q.pop_front()));
            if (first_wr < 0) first_wr = n;
            last_wr = n;
            n_wr++;
            if (n >= 5 && n <= 9) win_wr++;
         end
         if (issued - n_wr > max_out) max_out = issued - n_wr;
         if (done) begin
            done_cnt++;
            done_cyc = n;
         end
         if (!busy && done_cyc >= 0 && busy_low < 0) busy_low = n;
      end
   end

   int n_wr1 = 0, n_ce1 = 0, done1_cnt = 0;
   bit mon1 = 0;
   always @(negedge clk) begin
      if (mon1) begin
         if (ce1) begin
            chk("m1_address", 32'(addr1), 32'd0);
            n_ce1++;
         end
         if (wr1) begin
            chk("m1_din", 32'(din1), 32'(rom1_word));
            n_wr1++;
         end
         if (done1) done1_cnt++;
      end
   end

   task automatic start_run(input logic [RW-1:0] r);
      exp_q.delete();
      for (int p = 0; p < int'(r); p++)
         for (int i = 0; i < MEM; i++) exp_q.push_back(rom[i]);
      issued = 0; n_wr = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
      done_cnt = 0; busy_low = -1; win_wr = 0; max_out = 0;
      @(posedge clk); #1;
      start = 1'b1; rep = r; t0 = cyc; mon_on = 1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 0: full_n high, 1: full_n low in cycles 5..9, 2: random full_n + ignored start
   task automatic drive(input int mode, input int max_cyc, input bit expect_end);
      int n;
      n = cyc - t0;
      while (busy_low < 0 && n < max_cyc) begin
         case (mode)
            1:       full_n = !(n >= 5 && n <= 9);
            2:       full_n = 1'($urandom_range(0, 1));
            default: full_n = 1'b1;
         endcase
         if (mode == 2 && n == 10) begin
            start = 1'b1;
            rep   = 8'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n = cyc - t0;
      end
      full_n = 1'b1;
      start  = 1'b0;
      if (expect_end && busy_low < 0) chk("run_finished", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rep = '0; full_n = 1'b1;
      start1 = 1'b0; rep1 = '0; full_n1 = 1'b1;
      for (int i = 0; i < MEM; i++) rom[i] = DW'(16'h10 + i);
      rom1_word = DW'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rom_ce", 32'(rom_ce), 32'd0);
      chk("rst_rom_address", 32'(addr), 32'd0);
      chk("rst_write", 32'(wr), 32'd0);
      chk("rst_din", 32'(din), 32'd0);
      rst = 1'b0;

      // two passes, FIFO never full
      start_run(8'd2);
      drive(0, 60, 1'b1);
      chk("t1_writes", 32'(n_wr), 32'd16);
      chk("t1_first_write", 32'(first_wr), 32'd3);
      chk("t1_last_write", 32'(last_wr), 32'd18);
      chk("t1_done_cycle", 32'(done_cyc), 32'd19);
      chk("t1_busy_low", 32'(busy_low), 32'd20);
      chk("t1_done_pulses", 32'(done_cnt), 32'd1);
      chk("t1_leftover", 32'(exp_q.size()), 32'd0);

      // FIFO full for cycles 5..9
      start_run(8'd2);
      drive(1, 60, 1'b1);
      chk("t2_writes", 32'(n_wr), 32'd16);
      chk("t2_window_writes", 32'(win_wr), 32'd0);
      chk("t2_outstanding", 32'(max_out <= 2), 32'd1);
      chk("t2_last_write", 32'(last_wr), 32'd23);
      chk("t2_done_cycle", 32'(done_cyc), 32'd24);
      chk("t2_busy_low", 32'(busy_low), 32'd25);
      chk("t2_leftover", 32'(exp_q.size()), 32'd0);

      // random data and backpressure, stray start mid-run
      for (int i = 0; i < MEM; i++) rom[i] = DW'($urandom);
      start_run(8'd3);
      drive(2, 400, 1'b1);
      chk("t3_writes", 32'(n_wr), 32'd24);
      chk("t3_done_pulses", 32'(done_cnt), 32'd1);
      chk("t3_outstanding", 32'(max_out <= 2), 32'd1);
      chk("t3_leftover", 32'(exp_q.size()), 32'd0);

      // zero repeat count
      start_run(8'd0);
      drive(0, 10, 1'b1);
      chk("t4_done_cycle", 32'(done_cyc), 32'd1);
      chk("t4_busy_low", 32'(busy_low), 32'd2);
      chk("t4_rom_reads", 32'(issued), 32'd0);
      chk("t4_writes", 32'(n_wr), 32'd0);

      // reset asserted in cycle 7 of a run
      for (int i = 0; i < MEM; i++) rom[i] = DW'($urandom);
      start_run(8'd2);
      drive(0, 7, 1'b0);
      rst = 1'b1;
      mon_on = 0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_rom_ce", 32'(rom_ce), 32'd0);
      chk("mid_rst_rom_address", 32'(addr), 32'd0);
      chk("mid_rst_write", 32'(wr), 32'd0);
      chk("mid_rst_din", 32'(din), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      start_run(8'd1);
      drive(0, 40, 1'b1);
      chk("t5_writes", 32'(n_wr), 32'd8);
      chk("t5_first_write", 32'(first_wr), 32'd3);
      chk("t5_done_cycle", 32'(done_cyc), 32'd11);
      chk("t5_leftover", 32'(exp_q.size()), 32'd0);
      mon_on = 0;

      // single-word ROM, four passes
      @(posedge clk); #1;
      mon1 = 1; start1 = 1'b1; rep1 = 8'd4;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 40 && done1_cnt == 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("m1_writes", 32'(n_wr1), 32'd4);
      chk("m1_rom_reads", 32'(n_ce1), 32'd4);
      chk("m1_done_pulses", 32'(done1_cnt), 32'd1);
      chk("m1_busy_end", 32'(busy1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
